// File: rtl/uart_tx_fifo.sv
// UART TX FIFO: circular byte buffer feeding a one-shot launch FSM; define UART_TX_FIFO_OVF_FLAG_EN for the sticky overflow flag.
// Write-to-launch is 2 cycles; writes while full are dropped, launches wait on the transmitter busy/done handshake.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done,
  input  logic              i_Ovf_Clear,
  output logic              o_Overflow
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [2:0]        state_q, state_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        rd_dat_q, rd_dat_d;
  logic              head_vld_q, head_vld_d;
  logic              full, empty, wr_acc, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_acc  = i_Wr_DV & ~full;

  assign o_Full    = full;
  assign o_Empty   = empty;
  assign o_Count   = count_q;
  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;

  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    rd_ptr_d  = rd_ptr_q;
    pop       = 1'b0;
    case (state_q)
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (i_TX_Active) state_d = WAIT_DONE;
      WAIT_DONE: if (i_TX_Done) state_d = GAP;
      // Holding here until done drops keeps a 2-cycle done pulse from launching twice.
      GAP:       if (!i_TX_Done) state_d = IDLE;
      default: begin
        // IDLE, and any unreachable encoding behaves as IDLE.
        state_d = IDLE;
        if (!empty && head_vld_q) begin
          state_d   = SEND;
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = rd_dat_q;
          rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_acc && !pop)
      count_d = count_q + (ADDR_W+1)'(1);
    else if (!wr_acc && pop)
      count_d = count_q - (ADDR_W+1)'(1);
    // Head byte is read through a register, so the launch sees it one cycle after the count.
    head_vld_d = ~empty;
    rd_dat_d   = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      rd_dat_q   <= 8'h00;
      head_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      rd_dat_q   <= rd_dat_d;
      head_vld_q <= head_vld_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (i_Wr_DV && full)
      ovf_d = 1'b1;
    else if (i_Ovf_Clear)
      ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_Overflow = ovf_q;
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = i_Ovf_Clear;
  assign o_Overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue scoreboard plus a byte-timed transmitter model.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_dv;
  logic [7:0]      wr_byte;
  logic            full, empty;
  logic [ADDR_W:0] count;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_active, tx_done;
  logic            ovf_clr, ovf;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: FIFO contents and overflow flag.
  logic [7:0] model_q[$];
  bit         ovf_m = 1'b0;
  int         idle_run = 0;

  // Transmitter model configuration and state.
  bit tx_auto     = 1'b1;
  int bit_clks    = 4;
  int done_len_cfg = 2;
  int tx_phase    = 0;
  int tx_cnt      = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .o_Full(full), .o_Empty(empty), .o_Count(count),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .i_Ovf_Clear(ovf_clr), .o_Overflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Transmitter: a launch occupies 10 bit times of busy, then a 1- or 2-cycle done pulse.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tx_phase = 0; tx_active = 1'b0; tx_done = 1'b0;
      end else if (tx_dv) begin
        n_vec++;
        if (tx_phase != 0) begin
          n_err++;
          $display("FAIL double_launch: o_TX_DV=1 with transmitter phase %0d, required phase 0", tx_phase);
        end
        tx_phase = 1; tx_cnt = 10 * bit_clks;
      end else if (tx_phase == 1) begin
        if (!tx_auto) tx_active = 1'b0;
        else begin
          tx_active = 1'b1;
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_active = 1'b0;
            tx_done   = 1'b1;
            tx_cnt    = (done_len_cfg == 0) ? int'($urandom_range(1, 2)) : done_len_cfg;
            tx_phase  = 2;
          end
        end
      end else if (tx_phase == 2) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done  = 1'b0;
          tx_phase = 0;
        end
      end
    end
  end

  // Scoreboard: every cycle, apply the edge to the queue model and compare all status outputs.
  initial begin
    logic s_rst, s_wr, s_clr, full_b;
    logic [7:0] s_byte, exp_b;
    forever begin
      @(posedge clk);
      s_rst = rst; s_wr = wr_dv; s_byte = wr_byte; s_clr = ovf_clr;
      #2;
      if (s_rst) begin
        model_q.delete(); ovf_m = 1'b0; idle_run = 0;
      end else begin
        full_b = (model_q.size() == DEPTH);
        if (tx_dv) begin
          n_vec++;
          if (model_q.size() == 0) begin
            n_err++;
            $display("FAIL launch_empty: launch of %02h with model queue empty, required no launch", tx_byte);
          end else begin
            exp_b = model_q.pop_front();
            if (tx_byte !== exp_b) begin
              n_err++;
              $display("FAIL launch_byte: o_TX_Byte=%02h, required %02h", tx_byte, exp_b);
            end
          end
        end
        if (s_wr && !full_b) model_q.push_back(s_byte);
        if (OVF_EN) begin
          if (s_wr && full_b) ovf_m = 1'b1;
          else if (s_clr)     ovf_m = 1'b0;
        end
        if (tx_auto && model_q.size() > 0 && tx_phase == 0 && !tx_done && !tx_dv) idle_run++;
        else idle_run = 0;
        n_vec++;
        if (idle_run > 3) begin
          n_err++;
          $display("FAIL stall: %0d idle cycles with %0d queued, required launch within 3", idle_run, model_q.size());
          idle_run = 0;
        end
      end
      n_vec++;
      if (count !== (ADDR_W+1)'(model_q.size()) || empty !== (model_q.size() == 0) ||
          full !== (model_q.size() == DEPTH) || ovf !== ovf_m) begin
        n_err++;
        $display("FAIL status: count=%0d empty=%0b full=%0b ovf=%0b, required %0d/%0b/%0b/%0b",
                 count, empty, full, ovf, model_q.size(), model_q.size() == 0,
                 model_q.size() == DEPTH, ovf_m);
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #3;
      if (model_q.size() == 0 && tx_phase == 0 && !tx_done) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: %0d bytes still queued after %0d cycles, required 0", model_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00; ovf_clr = 1'b0;
    tx_auto = 1'b1; bit_clks = 4; done_len_cfg = 2;
    #3;
    n_vec++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || tx_dv !== 1'b0 ||
        tx_byte !== 8'h00 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: count=%0d empty=%0b full=%0b dv=%0b byte=%02h ovf=%0b, required 0/1/0/0/00/0",
               count, empty, full, tx_dv, tx_byte, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency();
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hA5;
    @(posedge clk); #1;
    n_vec++;
    if (count !== 5'd1) begin
      n_err++; $display("FAIL latency_count1: count=%0d, required 1", count);
    end
    @(negedge clk); wr_dv = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (tx_dv !== 1'b0) begin
      n_err++; $display("FAIL latency_early: o_TX_DV=%0b after edge k+1, required 0", tx_dv);
    end
    @(posedge clk); #1;
    n_vec++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'hA5 || count !== '0) begin
      n_err++;
      $display("FAIL latency_launch: dv=%0b byte=%02h count=%0d after edge k+2, required 1/a5/0", tx_dv, tx_byte, count);
    end
    @(posedge clk); #1;
    n_vec++;
    if (tx_dv !== 1'b0 || tx_byte !== 8'hA5) begin
      n_err++; $display("FAIL latency_pulse: dv=%0b byte=%02h one cycle later, required 0/a5", tx_dv, tx_byte);
    end
    wait_idle(200);
  endtask

  task automatic test_burst();
    logic [7:0] got[$];
    bit_clks = 4; done_len_cfg = 2; tx_auto = 1'b1;
    for (int c = 0; c < 1500 && got.size() < 16; c++) begin
      @(negedge clk);
      wr_dv   = (c < 16);
      wr_byte = 8'(c + 1);
      @(posedge clk); #1;
      if (tx_dv) got.push_back(tx_byte);
    end
    wr_dv = 1'b0;
    n_vec++;
    if (got.size() != 16) begin
      n_err++; $display("FAIL burst_launches: %0d launches, required 16", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== 8'(i + 1)) begin
        n_err++; $display("FAIL burst_order: launch %0d byte=%02h, required %02h", i, got[i], 8'(i + 1));
      end
    end
    wait_idle(300);
  endtask

  task automatic test_overflow();
    tx_auto = 1'b0; bit_clks = 4; done_len_cfg = 0;
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hEE;
    @(negedge clk); wr_dv = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      wr_dv = 1'b1; wr_byte = 8'($urandom_range(0, 255));
      ovf_clr = (i == 16);
      @(posedge clk); #1;
      if (i >= 15) begin
        n_vec++;
        if (count !== 5'd16 || full !== 1'b1) begin
          n_err++; $display("FAIL full_at_16: write %0d count=%0d full=%0b, required 16/1", i + 1, count, full);
        end
      end
      if (i == 16) begin
        n_vec++;
        if (ovf !== OVF_EN) begin
          n_err++; $display("FAIL ovf_set_wins: o_Overflow=%0b, required %0b", ovf, OVF_EN);
        end
      end
      @(negedge clk);
    end
    wr_dv = 1'b0; ovf_clr = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: o_Overflow=%0b, required 0", ovf);
    end
    @(negedge clk); ovf_clr = 1'b0;
    // Keep writing while the full FIFO drains, so drops land on pop edges.
    tx_auto = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_dv = 1'b1; wr_byte = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    wait_idle(2000);
  endtask

  task automatic test_simul_wr_pop();
    bit prev_done = 1'b0;
    bit seen = 1'b0;
    tx_auto = 1'b0; bit_clks = 1; done_len_cfg = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'h30 + 8'(i);
    end
    @(negedge clk); wr_dv = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (count !== 5'd3) begin
      n_err++; $display("FAIL simul_pre: count=%0d, required 3", count);
    end
    tx_auto = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev_done && !tx_done) begin seen = 1'b1; break; end
      prev_done = tx_done;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL simul_done_timeout: no done fall seen, required one");
    end
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'h77;
    @(posedge clk); #1;
    n_vec++;
    if (tx_dv !== 1'b1 || count !== 5'd3) begin
      n_err++; $display("FAIL simul_wr_pop: dv=%0b count=%0d, required 1/3", tx_dv, count);
    end
    @(negedge clk); wr_dv = 1'b0;
    wait_idle(300);
  endtask

  task automatic test_reset_mid();
    tx_auto = 1'b1; bit_clks = 4; done_len_cfg = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hC0 + 8'(i);
    end
    @(negedge clk); wr_dv = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (count !== 5'd5) begin
      n_err++; $display("FAIL reset_mid_pre: count=%0d, required 5", count);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (count !== '0 || empty !== 1'b1 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_async: count=%0d empty=%0b dv=%0b byte=%02h, required 0/1/0/00", count, empty, tx_dv, tx_byte);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (tx_dv !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_relaunch: o_TX_DV=1 %0d cycles after release, required 0", i);
      end
    end
    wait_idle(100);
  endtask

  task automatic test_random();
    int pct;
    tx_auto = 1'b1; bit_clks = 1; done_len_cfg = 0;
    for (int c = 0; c < 2400; c++) begin
      if (c % 200 == 0) pct = (c / 200 % 3 == 0) ? 10 : (c / 200 % 3 == 1) ? 70 : 30;
      @(negedge clk);
      wr_dv   = ($urandom_range(0, 99) < pct);
      wr_byte = 8'($urandom_range(0, 255));
      ovf_clr = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk); wr_dv = 1'b0; ovf_clr = 1'b0;
    wait_idle(1000);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_burst();
    test_overflow();
    test_simul_wr_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 SHALL have parameter ADDR_W, default 4, pointer width; equals log2(DEPTH).
REQ-003 SHALL have port i_Clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_Wr_DV  in  1  write strobe, one byte per high cycle.
REQ-006 SHALL have port i_Wr_Byte  in  8  byte to enqueue.
REQ-007 SHALL have port o_Full  out  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port o_Empty  out  1  FIFO holds 0 bytes.
REQ-009 SHALL have port o_Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have port o_TX_DV  out  1  one-cycle launch pulse to the downstream transmitter.
REQ-011 SHALL have port o_TX_Byte  out  8  byte presented with o_TX_DV; held until the next launch.
REQ-012 SHALL have port i_TX_Active  in  1  downstream transmitter busy.
REQ-013 SHALL have port i_TX_Done  in  1  downstream completion; may stay high 2 consecutive cycles.
REQ-014 SHALL have port i_Ovf_Clear  in  1  clears o_Overflow.
REQ-015 SHALL have port o_Overflow  out  1  sticky overflow flag.

Function
REQ-016 SHALL implement the storage as a circular buffer with ADDR_W-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL enqueue i_Wr_Byte on an edge with i_Wr_DV=1 and o_Full=0; a write while o_Full=1 SHALL be dropped, even if a pop occurs on the same edge.
REQ-018 SHALL leave o_Count unchanged on an edge with both an accepted write and a pop.
REQ-019 SHALL drive o_Full/o_Empty combinationally from the registered o_Count.
REQ-020 SHALL implement launch FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
REQ-021 IDLE: if o_Empty=0, go to SEND; in the same edge load o_TX_Byte from the head, advance the read pointer, and register o_TX_DV=1.
REQ-022 SEND: o_TX_DV=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-023 WAIT_BUSY: stay until i_TX_Active=1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: stay until i_TX_Done=1, then go to GAP.
REQ-025 GAP: stay until i_TX_Done=0, then go to IDLE; this prevents a double launch from a 2-cycle done pulse.
REQ-026 A byte written to an empty FIFO on edge k SHALL appear with o_TX_DV=1 after edge k+2.
REQ-027 SHALL keep o_TX_DV at 0 in every state except SEND.
REQ-028 SHALL treat unreachable FSM encodings as IDLE.

Reset
REQ-029 i_Reset=1 SHALL immediately force the FSM to IDLE, both pointers and o_Count to 0, o_TX_DV=0, o_TX_Byte=8'h00, and o_Overflow=0, independent of i_Clock.
REQ-030 Reset mid-transfer SHALL discard all queued bytes; an in-flight downstream byte is not tracked.
REQ-031 SHALL leave storage-array contents undefined after reset; they are never read before being written.

Configuration
REQ-032 Macro UART_TX_FIFO_OVF_FLAG_EN: when defined, o_Overflow SHALL set on any dropped write and clear on i_Ovf_Clear=1.
REQ-033 If set and clear conditions coincide on one edge, set SHALL win.
REQ-034 Without UART_TX_FIFO_OVF_FLAG_EN, o_Overflow SHALL be constant 0, i_Ovf_Clear SHALL be ignored, and no flag register SHALL be inferred.

Verification
REQ-035 Write 8'hA5 into an empty FIFO at edge k -> o_TX_DV=1 with o_TX_Byte=8'hA5 after edge k+2; o_Count returns to 0.
REQ-036 Burst writes 8'h01..8'h10 (16 bytes), transmitter model at 4 clocks/bit -> 16 launches in order; no second launch before i_TX_Done falls.
REQ-037 17 writes while stalled (i_TX_Active held 0 after the first launch) -> o_Full=1 at o_Count=16; 17th byte dropped; o_Overflow=1 when the macro is defined, else 0.
REQ-038 Write and pop on the same edge with o_Count=3 -> o_Count stays 3; pointers wrap correctly across entry 15->0.
REQ-039 Assert i_Reset during WAIT_DONE with o_Count=5 -> immediately o_Count=0, o_Empty=1, o_TX_DV=0; no launch after release until a new write.
REQ-040 i_Ovf_Clear and a dropped write on the same edge (macro defined) -> o_Overflow=1.
